// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-control bundle between the ID-side hazard detector and the pipeline register controls.
// The slave side is the stall/flush scheduler; the master side is the pipeline that feeds it.
interface hazard_stall_ctrl_if;
    logic [4:0] IF_ID_RS1;
    logic [4:0] IF_ID_RS2;
    logic [4:0] ID_EX_RD;
    logic       ID_EX_MEMREAD;
    logic       MDIV_START;
    logic       BRANCH_TAKEN;
    logic       IMEM_BUSYWAIT;
    logic       DMEM_BUSYWAIT;
    logic       PC_STALL;
    logic       IF_ID_STALL;
    logic       IF_ID_FLUSH;
    logic       ID_EX_STALL;
    logic       ID_EX_FLUSH;
    logic       EX_MEM_STALL;
    logic       EX_MEM_FLUSH;
    logic       MDIV_BUSY;
    logic       MDIV_DONE;

    modport master (
        output IF_ID_RS1, IF_ID_RS2, ID_EX_RD, ID_EX_MEMREAD, MDIV_START,
               BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
        input  PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH,
               EX_MEM_STALL, EX_MEM_FLUSH, MDIV_BUSY, MDIV_DONE
    );

    modport slave (
        input  IF_ID_RS1, IF_ID_RS2, ID_EX_RD, ID_EX_MEMREAD, MDIV_START,
               BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
        output PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH,
               EX_MEM_STALL, EX_MEM_FLUSH, MDIV_BUSY, MDIV_DONE
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32IM pipeline: memory freezes, M-extension EX occupancy,
// taken-branch flushes and load-use bubbles, resolved with a fixed priority each cycle.
module hazard_stall_ctrl #(
    parameter int unsigned MDIV_LATENCY = 32,
    parameter int unsigned CNT_W        = 6
) (
    input logic                 CLK,
    input logic                 RESET,
    hazard_stall_ctrl_if.slave  bus
);

    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_MDIV  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDIV_LATENCY - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_busy;
    logic load_use;
    logic cnt_zero;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_flush, mdiv_busy, mdiv_done;

    assign mem_busy = bus.IMEM_BUSYWAIT | bus.DMEM_BUSYWAIT;
    assign cnt_zero = (cnt_q == '0);
    assign load_use = bus.ID_EX_MEMREAD && (bus.ID_EX_RD != 5'd0) &&
                      ((bus.ID_EX_RD == bus.IF_ID_RS1) || (bus.ID_EX_RD == bus.IF_ID_RS2));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mdiv_busy    = 1'b0;
        mdiv_done    = 1'b0;

        if (!RESET) begin
            mdiv_busy = (state_q == ST_MDIV);
            if (mem_busy) begin
                // Whole pipeline frozen; the divider keeps counting so DONE only slips, never stretches.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (state_q == ST_MDIV) begin
                if (!cnt_zero) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                end else begin
                    // MDIV_START is still high for the same op here, so it must not retrigger.
                    mdiv_done = 1'b1;
                    state_d   = ST_RUN;
                end
            end else if (bus.BRANCH_TAKEN) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (bus.MDIV_START) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                state_d      = ST_MDIV;
                cnt_d        = CNT_LOAD;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PC_STALL     = pc_stall;
    assign bus.IF_ID_STALL  = if_id_stall;
    assign bus.IF_ID_FLUSH  = if_id_flush;
    assign bus.ID_EX_STALL  = id_ex_stall;
    assign bus.ID_EX_FLUSH  = id_ex_flush;
    assign bus.EX_MEM_STALL = ex_mem_stall;
    assign bus.EX_MEM_FLUSH = ex_mem_flush;
    assign bus.MDIV_BUSY    = mdiv_busy;
    assign bus.MDIV_DONE    = mdiv_done;

    // A register is either held or loaded with a bubble, never both.
    a_ifid_excl:  assert property (@(posedge CLK) !(if_id_stall && if_id_flush));
    a_idex_excl:  assert property (@(posedge CLK) !(id_ex_stall && id_ex_flush));
    a_exmem_excl: assert property (@(posedge CLK) !(ex_mem_stall && ex_mem_flush));
    a_done_run:   assert property (@(posedge CLK) disable iff (RESET) mdiv_done |-> mdiv_busy);

endmodule
